stage_fetch: RTL
================

# stage_fetch

Fetch stage and PC unit for the 5-stage pipelined processor. It owns the program counter, drives the synchronous instruction-memory address, and loads the F/D pipeline latch. It consumes the execute stage's redirect (`take_branch` or any jump) and target `pc_in`, squashes wrong-path instructions, and produces the `pc_plus_1` and `pc_upper_5` values that the decode and execute stages consume.

## Interface
Parameters:
- `ADDR_W`, default 12: instruction-memory word-address width.
- `NOP`, default 32'h0000_0000: bubble instruction inserted on squash.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `stall`  in  1  hazard-unit hold; freezes PC and the F/D latch.
- `ex_redirect`  in  1  execute changes flow. Covers taken bne/blt/bex and j/jal/jr.
- `ex_pc_in`  in  32  redirect target from execute, word address.
- `imem_addr`  out  ADDR_W  address to the synchronous ROM; the ROM samples it on the clock edge.
- `imem_q`  in  32  ROM data; valid the cycle after its address is sampled.
- `fd_insn`  out  32  F/D latched instruction.
- `fd_pc_plus_1`  out  32  F/D latched PC+1.
- `fd_pc_upper_5`  out  5  equals `fd_pc_plus_1[31:27]`.
- `fd_valid`  out  1  F/D contents are a real instruction, not a bubble.
- `flush_dx`  out  1  combinational; equals `ex_redirect`. The D/X latch loads a bubble on this edge.
- `pc`  out  32  current fetch PC; `imem_q` corresponds to this PC.
- `fetch_count`  out  32  number of instructions accepted into F/D.
- `squash_count`  out  16  number of redirects taken.

## Operation
- Next-PC (`pc_next`) is combinational. The first matching rule applies:
  - `!reset_n` → 0
  - `ex_redirect` → `ex_pc_in`
  - `stall` → `pc`
  - otherwise → `pc + 1`
- `imem_addr = pc_next[ADDR_W-1:0]`. The ROM and `pc` update on the same edge, so after each edge `imem_q` holds the instruction at `pc`.
- F/D latch on each edge. The first matching rule applies:
  - reset → `fd_insn = NOP`, `fd_pc_plus_1 = 0`, `fd_valid = 0`
  - `ex_redirect` → `fd_insn = NOP`, `fd_valid = 0`, `fd_pc_plus_1` unchanged
  - `stall` → hold all F/D fields
  - otherwise → `fd_insn = imem_q`, `fd_pc_plus_1 = pc + 1`, `fd_valid = 1`
- Redirect beats stall. The stalled instruction is younger than the branch in execute and is discarded.
- `flush_dx` is asserted whenever `ex_redirect` is high. The instruction in decode and the instruction in fetch are both squashed, so the branch penalty is 2 cycles.
- Arithmetic:
  - `pc + 1` is 32-bit modulo: 32'hFFFF_FFFF wraps to 0.
  - Bits of `pc_next` at and above `ADDR_W` are kept in `pc` and not sent to `imem_addr`.
- Counters:
  - `fetch_count` increments on each edge where F/D loads with `fd_valid = 1`. It wraps modulo 2^32.
  - `squash_count` increments on each edge where `ex_redirect` is high. It wraps modulo 2^16.
  - Both counters clear on reset.

## Timing
- Reset values:
  - `pc = 0`, `fd_insn = NOP`, `fd_pc_plus_1 = 0`, `fd_pc_upper_5 = 0`, `fd_valid = 0`, counters = 0.
  - During reset, `imem_addr = 0`.
- First edge with `reset_n = 1`:
  - F/D captures the instruction at address 0, with `fd_pc_plus_1 = 1`.
  - `pc` becomes 1.
- Fetch-to-decode latency is 1 cycle after `pc` is established.
- Throughput is 1 instruction per cycle when there is no stall and no redirect.
- Redirect:
  - On the edge where `ex_redirect` is sampled, `pc` becomes `ex_pc_in` and F/D becomes a bubble.
  - On the next edge, F/D holds the target instruction with `fd_pc_plus_1 = ex_pc_in + 1`.
- Stall:
  - Any number of consecutive stalled cycles leaves `pc`, all F/D outputs and `fetch_count` unchanged.
  - `imem_addr` stays at `pc`, so `imem_q` stays stable.
- Back-to-back redirects on consecutive cycles: each one is honored and each increments `squash_count`. The later target wins.
- Reset asserted mid-operation overrides redirect and stall on that edge.

## Test plan
- Reset then free-run with ROM[i] = 32'h1000_0000 + i:
  - each successive cycle `fd_insn` = 32'h1000_0000, 32'h1000_0001, …
  - `fd_pc_plus_1` = 1, 2, …
  - after 5 fetches, `fetch_count = 5`.
- Stall held for 3 cycles while `fd_insn` = ROM[4]:
  - `fd_insn`, `fd_pc_plus_1 = 5`, `pc` and `fetch_count` are unchanged for all 3 cycles.
  - the cycle after release, F/D holds ROM[5].
- `ex_redirect = 1` with `ex_pc_in = 100` for one cycle:
  - `flush_dx = 1` in that cycle.
  - next cycle: `fd_valid = 0`, `fd_insn = NOP`, `pc = 100`.
  - the cycle after: `fd_insn = ROM[100]`, `fd_pc_plus_1 = 101`.
  - `squash_count = 1`.
- `stall = 1` and `ex_redirect = 1` (`ex_pc_in = 40`) in the same cycle: redirect wins, giving `pc = 40` and an F/D bubble.
- `ex_pc_in = 32'hFFFF_FFFF`:
  - after two edges, `fd_pc_plus_1 = 0`, `fd_pc_upper_5 = 0`, `pc = 0`, and `imem_addr` wraps.
- `reset_n = 0` during a redirect cycle:
  - all outputs return to their reset values.
  - the first post-reset fetch is ROM[0].

Source files
------------

// File: rtl/stage_fetch.sv
// stage_fetch: fetch stage and PC unit of the 5-stage pipeline.
//
// Owns the program counter and drives the address of the synchronous instruction ROM.
// Loads the F/D pipeline latch. Redirects from execute (taken branch or jump) take
// priority over a hazard stall. A redirect squashes the instruction being fetched, and
// flush_dx squashes the one in decode.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        synchronous active-low reset
//   stall          hazard-unit hold; freezes PC and the F/D latch
//   ex_redirect    execute changes flow (taken bne/blt/bex, j/jal/jr)
//   ex_pc_in       redirect target word address
//   imem_addr      address to the synchronous ROM; this is the *next* PC
//   imem_q         ROM data for the current pc
//   fd_insn        F/D instruction
//   fd_pc_plus_1   F/D PC+1
//   fd_pc_upper_5  fd_pc_plus_1[31:27]
//   fd_valid       F/D holds a real instruction, not a bubble
//   flush_dx       combinational copy of ex_redirect; bubbles the D/X latch
//   pc             current fetch PC
//   fetch_count    instructions accepted into F/D (mod 2^32)
//   squash_count   redirects taken (mod 2^16)
module stage_fetch #(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              ex_redirect,
    input  logic [31:0]       ex_pc_in,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    output logic [31:0]       fd_insn,
    output logic [31:0]       fd_pc_plus_1,
    output logic [4:0]        fd_pc_upper_5,
    output logic              fd_valid,
    output logic              flush_dx,
    output logic [31:0]       pc,
    output logic [31:0]       fetch_count,
    output logic [15:0]       squash_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus_1;
    logic [31:0] pc_next;
    logic [31:0] fd_insn_q;
    logic [31:0] fd_pc_plus_1_q;
    logic        fd_valid_q;
    logic [31:0] fetch_count_q;
    logic [15:0] squash_count_q;

    assign pc_plus_1 = pc_q + 32'd1;  // wraps modulo 2^32

    // The ROM samples imem_addr on the same edge that pc takes pc_next.
    // After each edge, imem_q therefore always matches pc.
    always_comb begin
        pc_next = pc_plus_1;
        if (!reset_n) begin
            pc_next = 32'd0;
        end else if (ex_redirect) begin
            pc_next = ex_pc_in;
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    // Upper PC bits stay in pc but are not sent to the ROM.
    assign imem_addr = pc_next[ADDR_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q           <= 32'd0;
            fd_insn_q      <= NOP;
            fd_pc_plus_1_q <= 32'd0;
            fd_valid_q     <= 1'b0;
            fetch_count_q  <= 32'd0;
            squash_count_q <= 16'd0;
        end else begin
            pc_q <= pc_next;
            if (ex_redirect) begin
                // The instruction in fetch is on the wrong path, even when it is stalled.
                // fd_pc_plus_1 is left unchanged because a bubble does not use it.
                fd_insn_q      <= NOP;
                fd_valid_q     <= 1'b0;
                squash_count_q <= squash_count_q + 16'd1;
            end else if (!stall) begin
                fd_insn_q      <= imem_q;
                fd_pc_plus_1_q <= pc_plus_1;
                fd_valid_q     <= 1'b1;
                fetch_count_q  <= fetch_count_q + 32'd1;
            end
        end
    end

    assign pc            = pc_q;
    assign fd_insn       = fd_insn_q;
    assign fd_pc_plus_1  = fd_pc_plus_1_q;
    assign fd_pc_upper_5 = fd_pc_plus_1_q[31:27];
    assign fd_valid      = fd_valid_q;
    assign fetch_count   = fetch_count_q;
    assign squash_count  = squash_count_q;
    assign flush_dx      = ex_redirect;

endmodule
